// File: rtl/sens_event_gen_pkg.sv
// sens_event_pkg: shared constants and types for the sensitivity-list event generator.
//   EDGE_ANY / EDGE_POS : per-bit edge_mode encoding
//   N_SIG_DEF / CNT_W_DEF : default widths
//   report_t : {mask, count, merged} report record at the default widths
package sens_event_pkg;

    localparam logic EDGE_ANY = 1'b0;
    localparam logic EDGE_POS = 1'b1;

    localparam int unsigned N_SIG_DEF = 4;
    localparam int unsigned CNT_W_DEF = 8;

    typedef struct packed {
        logic [N_SIG_DEF-1:0] mask;
        logic [CNT_W_DEF-1:0] count;
        logic                 merged;
    } report_t;

endpackage

// File: rtl/sens_event_gen_if.sv
// sens_event_gen_if: valid/ready report channel from the event generator to its consumer.
//   ev_valid  : report slot holds an unconsumed report (master drives)
//   ev_ready  : consumer accepts when ev_valid && ev_ready at a rising edge (slave drives)
//   ev_mask   : bits that fired for the held report
//   ev_count  : event count associated with the held report
//   ev_merged : held report absorbed at least one later trigger
interface sens_event_gen_if
    import sens_event_pkg::*;
#(
    parameter int unsigned N_SIG = N_SIG_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic             ev_valid;
    logic             ev_ready;
    logic [N_SIG-1:0] ev_mask;
    logic [CNT_W-1:0] ev_count;
    logic             ev_merged;

    modport master (
        output ev_valid,
        output ev_mask,
        output ev_count,
        output ev_merged,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_mask,
        input  ev_count,
        input  ev_merged,
        output ev_ready
    );

endinterface

// File: rtl/sens_event_gen_hit_detect.sv
// sens_hit_detect: history register plus per-bit hit logic.
//   clk, rst    : clock, async active-high reset
//   sig_i       : watched signals
//   edge_mode_i : per bit EDGE_ANY (any change) or EDGE_POS (rising only)
//   en_i        : detection enable; history updates regardless
//   hit_o       : per-bit hit for the current sample (combinational)
module sens_hit_detect
    import sens_event_pkg::*;
#(
    parameter int unsigned N_SIG = N_SIG_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SIG-1:0] sig_i,
    input  logic [N_SIG-1:0] edge_mode_i,
    input  logic             en_i,
    output logic [N_SIG-1:0] hit_o
);

    logic [N_SIG-1:0] prev_q;

    // Reset value 0 makes a 1 on the first sample after reset count as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= sig_i;
        end
    end

    always_comb begin
        hit_o = '0;
        for (int i = 0; i < int'(N_SIG); i++) begin
            if (edge_mode_i[i] == EDGE_POS) begin
                hit_o[i] = en_i & sig_i[i] & ~prev_q[i];
            end else begin
                hit_o[i] = en_i & (sig_i[i] ^ prev_q[i]);
            end
        end
    end

endmodule

// File: rtl/sens_event_gen.sv
// sens_event_gen: sampled sensitivity-list trigger source.
//   clk, rst    : clock, async active-high reset
//   sig_i       : watched signals
//   edge_mode_i : per bit EDGE_ANY / EDGE_POS
//   en_i        : detection enable
//   clr_i       : synchronous counter clear (wins over a same-cycle trigger)
//   ev_pulse_o  : one-cycle strobe, the cycle after a trigger
//   ev_cnt_o    : wrapping event count
//   ev          : report channel (master side), single-entry slot with coalescing
module sens_event_gen
    import sens_event_pkg::*;
#(
    parameter int unsigned N_SIG = N_SIG_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SIG-1:0]         sig_i,
    input  logic [N_SIG-1:0]         edge_mode_i,
    input  logic                     en_i,
    input  logic                     clr_i,
    output logic                     ev_pulse_o,
    output logic [CNT_W-1:0]         ev_cnt_o,
    sens_event_gen_if.master         ev
);

    logic [N_SIG-1:0] hit;
    logic             trigger;
    logic             accept;

    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             valid_q,  valid_d;
    logic [N_SIG-1:0] mask_q,   mask_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             merged_q, merged_d;

    sens_hit_detect #(
        .N_SIG (N_SIG)
    ) u_hit_detect (
        .clk         (clk),
        .rst         (rst),
        .sig_i       (sig_i),
        .edge_mode_i (edge_mode_i),
        .en_i        (en_i),
        .hit_o       (hit)
    );

    // Several bits firing together still make a single trigger.
    assign trigger = |hit;
    assign accept  = valid_q & ev.ev_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (trigger) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        valid_d  = valid_q;
        mask_d   = mask_q;
        count_d  = count_q;
        merged_d = merged_q;
        if ((!valid_q || accept) && trigger) begin
            valid_d  = 1'b1;
            mask_d   = hit;
            count_d  = cnt_d;
            merged_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b0;
        end else if (valid_q && trigger) begin
            // Consumer is stalled: fold the new trigger into the held report.
            mask_d   = mask_q | hit;
            count_d  = cnt_d;
            merged_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            mask_q   <= '0;
            count_q  <= '0;
            merged_q <= 1'b0;
        end else begin
            pulse_q  <= trigger;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            mask_q   <= mask_d;
            count_q  <= count_d;
            merged_q <= merged_d;
        end
    end

    assign ev_pulse_o   = pulse_q;
    assign ev_cnt_o     = cnt_q;
    assign ev.ev_valid  = valid_q;
    assign ev.ev_mask   = mask_q;
    assign ev.ev_count  = count_q;
    assign ev.ev_merged = merged_q;

endmodule

// File: tb/tb_sens_event_gen.sv
// Bench for sens_event_gen: bits 0,1 = x,y (any change), bit 2 = z (posedge), bit 3 idle.
module tb_sens_event_gen;
    import sens_event_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sig = 4'b0000;
    logic [3:0] edge_mode = {1'b0, EDGE_POS, EDGE_ANY, EDGE_ANY};
    logic       en = 1'b1;
    logic       clr = 1'b0;
    logic       ev_pulse;
    logic [7:0] ev_cnt;

    int checks = 0;
    int errors = 0;

    report_t exp_q[$];

    sens_event_gen_if #(.N_SIG(4), .CNT_W(8)) ev ();

    sens_event_gen #(
        .N_SIG (4),
        .CNT_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_i       (sig),
        .edge_mode_i (edge_mode),
        .en_i        (en),
        .clr_i       (clr),
        .ev_pulse_o  (ev_pulse),
        .ev_cnt_o    (ev_cnt),
        .ev          (ev)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive a new sample, let one edge pass, check pulse and count.
    task automatic step(input logic [3:0] s, input logic exp_pulse, input logic [7:0] exp_cnt,
                        input string name);
        sig = s;
        @(posedge clk);
        #1;
        chk({name, " pulse"}, {31'd0, ev_pulse}, {31'd0, exp_pulse});
        chk({name, " cnt"}, {24'd0, ev_cnt}, {24'd0, exp_cnt});
    endtask

    task automatic push(input logic [3:0] m, input logic [7:0] c, input logic mg);
        report_t r;
        r.mask   = m;
        r.count  = c;
        r.merged = mg;
        exp_q.push_back(r);
    endtask

    // Monitor: every accepted report is compared against the scoreboard queue.
    always @(negedge clk) begin
        if (!rst && ev.ev_valid && ev.ev_ready) begin
            if (exp_q.size() == 0) begin
                chk("report unexpected", exp_q.size(), 1);
            end else begin
                report_t e;
                e = exp_q.pop_front();
                chk("report mask", {28'd0, ev.ev_mask}, {28'd0, e.mask});
                chk("report count", {24'd0, ev.ev_count}, {24'd0, e.count});
                chk("report merged", {31'd0, ev.ev_merged}, {31'd0, e.merged});
            end
        end
    end

    initial begin
        logic [3:0] cur;
        ev.ev_ready = 1'b1;
        #2;
        chk("reset pulse", {31'd0, ev_pulse}, 0);
        chk("reset cnt", {24'd0, ev_cnt}, 0);
        chk("reset valid", {31'd0, ev.ev_valid}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Mixed sensitivity
        step(4'b0000, 1'b0, 8'd0, "idle");
        push(4'b0100, 8'd1, 1'b0);
        step(4'b0100, 1'b1, 8'd1, "z rise");
        step(4'b0000, 1'b0, 8'd1, "z fall");
        push(4'b0010, 8'd2, 1'b0);
        step(4'b0010, 1'b1, 8'd2, "y rise");
        push(4'b0010, 8'd3, 1'b0);
        step(4'b0000, 1'b1, 8'd3, "y fall");

        // Simultaneous x and z rise: one trigger
        push(4'b0101, 8'd4, 1'b0);
        step(4'b0101, 1'b1, 8'd4, "xz rise");
        push(4'b0001, 8'd5, 1'b0);
        step(4'b0000, 1'b1, 8'd5, "x fall z fall");
        step(4'b0000, 1'b0, 8'd5, "drain");

        // Backpressure: three triggers coalesce
        ev.ev_ready = 1'b0;
        step(4'b0001, 1'b1, 8'd6, "bp x");
        step(4'b0011, 1'b1, 8'd7, "bp y");
        step(4'b0010, 1'b1, 8'd8, "bp x");
        chk("bp valid", {31'd0, ev.ev_valid}, 1);
        chk("bp mask", {28'd0, ev.ev_mask}, 32'h3);
        chk("bp merged", {31'd0, ev.ev_merged}, 1);
        chk("bp count", {24'd0, ev.ev_count}, 8);
        push(4'b0011, 8'd8, 1'b1);
        ev.ev_ready = 1'b1;
        step(4'b0010, 1'b0, 8'd8, "bp release");
        chk("bp drained valid", {31'd0, ev.ev_valid}, 0);

        // Wrap: toggle x until count passes 255
        cur = 4'b0010;
        for (int i = 9; i <= 256; i++) begin
            cur = cur ^ 4'b0001;
            push(4'b0001, i[7:0], 1'b0);
            step(cur, 1'b1, i[7:0], "wrap");
        end

        // Clear beats a same-cycle trigger
        cur = cur ^ 4'b0001;
        push(4'b0001, 8'd1, 1'b0);
        step(cur, 1'b1, 8'd1, "pre clr");
        cur = cur ^ 4'b0001;
        clr = 1'b1;
        push(4'b0001, 8'd0, 1'b0);
        step(cur, 1'b1, 8'd0, "clr trig");
        clr = 1'b0;

        // Enable low: history follows, no hits
        en = 1'b0;
        cur = cur ^ 4'b0001;
        step(cur, 1'b0, 8'd0, "en0 toggle");
        cur = cur ^ 4'b0001;
        step(cur, 1'b0, 8'd0, "en0 toggle");
        cur = cur ^ 4'b0001;
        step(cur, 1'b0, 8'd0, "en0 toggle");
        en = 1'b1;
        step(cur, 1'b0, 8'd0, "en1 steady");

        // Async reset with a held report
        ev.ev_ready = 1'b0;
        cur = cur ^ 4'b0001;
        step(cur, 1'b1, 8'd1, "pre rst");
        chk("pre rst valid", {31'd0, ev.ev_valid}, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst pulse", {31'd0, ev_pulse}, 0);
        chk("rst cnt", {24'd0, ev_cnt}, 0);
        chk("rst valid", {31'd0, ev.ev_valid}, 0);
        chk("rst mask", {28'd0, ev.ev_mask}, 0);
        chk("rst count", {24'd0, ev.ev_count}, 0);
        chk("rst merged", {31'd0, ev.ev_merged}, 0);
        @(posedge clk);
        #1;
        ev.ev_ready = 1'b1;
        rst = 1'b0;
        // First edge after release compares against 0: y high fires
        push(4'b0010, 8'd1, 1'b0);
        step(4'b0010, 1'b1, 8'd1, "post rst");
        step(4'b0010, 1'b0, 8'd1, "post rst idle");
        step(4'b0010, 1'b0, 8'd1, "post rst idle");

        chk("scoreboard empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
